// File: rtl/aquaflex_pkg.sv
// Shared types and lookup tables for the aquaflex-5a sequencer: FSM states,
// the peristaltic phase pattern and the switch4 routing masks.
package aquaflex_pkg;

    localparam int SEL_W     = 3;
    localparam int CNT_W     = 8;
    localparam int PH_W      = 3;
    localparam int NUM_PORTS = 5;
    localparam logic [2:0] STEP_LAST = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROUTE_IN,
        ST_FILL,
        ST_MIX,
        ST_ROUTE_OUT,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } mask_pair_t;

    // Closed-valve pattern for one stroke; six steps walk the occlusion along the tube.
    function automatic logic [PH_W-1:0] phase_pat(input logic [2:0] step);
        case (step)
            3'd0:    phase_pat = 3'b100;
            3'd1:    phase_pat = 3'b110;
            3'd2:    phase_pat = 3'b010;
            3'd3:    phase_pat = 3'b011;
            3'd4:    phase_pat = 3'b001;
            3'd5:    phase_pat = 3'b101;
            default: phase_pat = 3'b000;
        endcase
    endfunction

    function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
        sel_valid = (sel < SEL_W'(NUM_PORTS));
    endfunction

    // Masks for sw0 (a) and sw1 (b) that connect a source port to PumpA.
    function automatic mask_pair_t in_masks(input logic [SEL_W-1:0] sel);
        case (sel)
            3'd0:    in_masks = '{a: 4'b0000, b: 4'b1100};
            3'd1:    in_masks = '{a: 4'b1010, b: 4'b0110};
            3'd2:    in_masks = '{a: 4'b0110, b: 4'b0110};
            3'd3:    in_masks = '{a: 4'b0011, b: 4'b0110};
            3'd4:    in_masks = '{a: 4'b0000, b: 4'b0101};
            default: in_masks = '{a: 4'b0000, b: 4'b0000};
        endcase
    endfunction

    // Masks for sw2 (a) and sw3 (b) that connect PumpC to a sink port.
    function automatic mask_pair_t out_masks(input logic [SEL_W-1:0] sel);
        case (sel)
            3'd0:    out_masks = '{a: 4'b1010, b: 4'b0000};
            3'd1:    out_masks = '{a: 4'b0110, b: 4'b0101};
            3'd2:    out_masks = '{a: 4'b0110, b: 4'b1001};
            3'd3:    out_masks = '{a: 4'b0110, b: 4'b0011};
            3'd4:    out_masks = '{a: 4'b0011, b: 4'b0000};
            default: out_masks = '{a: 4'b0000, b: 4'b0000};
        endcase
    endfunction

endpackage

// File: rtl/aquaflex_peristaltic_phaser.sv
// Step prescaler, step index and stroke counter shared by PumpA, Mixer1 and PumpC.
// o_phase is the pattern for the coming cycle so the caller can register it directly.
module aquaflex_peristaltic_phaser
    import aquaflex_pkg::*;
#(
    parameter int STEP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_count,
    output logic [PH_W-1:0]  o_phase,
    output logic             o_last
);

    localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(STEP_CYCLES - 1);

    logic [PW-1:0]    r_presc;
    logic [PW-1:0]    w_presc_nxt;
    logic [2:0]       r_step;
    logic [2:0]       w_step_nxt;
    logic [CNT_W-1:0] r_stroke;
    logic [CNT_W-1:0] w_stroke_nxt;
    logic [CNT_W-1:0] r_count;
    logic             r_run;
    logic             w_run_nxt;
    logic             w_step_end;
    logic             w_stroke_end;
    logic             w_count_end;

    assign w_step_end   = (r_presc == PRESC_MAX);
    assign w_stroke_end = w_step_end && (r_step == STEP_LAST);
    assign w_count_end  = (r_stroke == r_count - CNT_W'(1));
    assign o_last       = r_run && w_stroke_end && w_count_end;

    always_comb begin
        w_presc_nxt  = r_presc;
        w_step_nxt   = r_step;
        w_stroke_nxt = r_stroke;
        w_run_nxt    = r_run;
        if (i_start) begin
            w_presc_nxt  = '0;
            w_step_nxt   = '0;
            w_stroke_nxt = '0;
            w_run_nxt    = 1'b1;
        end else if (r_run) begin
            if (w_step_end) begin
                w_presc_nxt = '0;
                if (r_step == STEP_LAST) begin
                    w_step_nxt   = '0;
                    w_stroke_nxt = r_stroke + CNT_W'(1);
                    if (w_count_end) begin
                        w_run_nxt = 1'b0;
                    end
                end else begin
                    w_step_nxt = r_step + 3'd1;
                end
            end else begin
                w_presc_nxt = r_presc + PW'(1);
            end
        end
    end

    assign o_phase = w_run_nxt ? phase_pat(w_step_nxt) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run <= 1'b0;
        end else begin
            r_run <= w_run_nxt;
        end
    end

    always_ff @(posedge clk) begin
        r_presc  <= w_presc_nxt;
        r_step   <= w_step_nxt;
        r_stroke <= w_stroke_nxt;
        if (i_start) begin
            r_count <= i_count;
        end
    end

endmodule

// File: rtl/aquaflex_seq_ctrl.sv
// Command sequencer for the aquaflex-5a path: route-in, fill, mix, route-out, drain.
// Define AQUAFLEX_SEQ_ABORT_EN to add the abort input.
module aquaflex_seq_ctrl
    import aquaflex_pkg::*;
#(
    parameter int STEP_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [SEL_W-1:0] cmd_in_sel,
    input  logic [SEL_W-1:0] cmd_out_sel,
    input  logic [CNT_W-1:0] cmd_fill,
    input  logic [CNT_W-1:0] cmd_mix,
    input  logic [CNT_W-1:0] cmd_drain,
    output logic [3:0]       sw0_open,
    output logic [3:0]       sw1_open,
    output logic [3:0]       sw2_open,
    output logic [3:0]       sw3_open,
    output logic [PH_W-1:0]  pump_a_phase,
    output logic [PH_W-1:0]  pump_c_phase,
    output logic [PH_W-1:0]  mix_phase,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef AQUAFLEX_SEQ_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [SW-1:0]    r_settle;
    logic             w_settle_end;

    logic [SEL_W-1:0] r_in_sel;
    logic [SEL_W-1:0] r_out_sel;
    logic [CNT_W-1:0] r_fill;
    logic [CNT_W-1:0] r_mix;
    logic [CNT_W-1:0] r_drain;

    logic             w_acc;
    logic             w_sel_ok;
    logic [SEL_W-1:0] w_in_sel;
    mask_pair_t       w_in_m;
    mask_pair_t       w_out_m;

    logic             w_ph_start;
    logic [CNT_W-1:0] w_ph_count;
    logic [PH_W-1:0]  w_phase;
    logic             w_ph_last;

    logic [3:0]       r_sw0;
    logic [3:0]       r_sw1;
    logic [3:0]       r_sw2;
    logic [3:0]       r_sw3;
    logic [PH_W-1:0]  r_pump_a;
    logic [PH_W-1:0]  r_pump_c;
    logic [PH_W-1:0]  r_mix_ph;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_ready;

    assign w_acc        = cmd_valid && r_ready && (r_state == ST_IDLE);
    assign w_sel_ok     = sel_valid(cmd_in_sel) && sel_valid(cmd_out_sel);
    assign w_settle_end = (r_settle == SETTLE_MAX);

    // On the accept cycle the fields are not latched yet, so route-in masks come from the port.
    assign w_in_sel = (r_state == ST_IDLE) ? cmd_in_sel : r_in_sel;
    assign w_in_m   = in_masks(w_in_sel);
    assign w_out_m  = out_masks(r_out_sel);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_acc && w_sel_ok) begin
                    w_state_nxt = ST_ROUTE_IN;
                end
            end
            ST_ROUTE_IN: begin
                if (w_settle_end) begin
                    if (r_fill != '0)     w_state_nxt = ST_FILL;
                    else if (r_mix != '0) w_state_nxt = ST_MIX;
                    else                  w_state_nxt = ST_ROUTE_OUT;
                end
            end
            ST_FILL: begin
                if (w_ph_last) begin
                    w_state_nxt = (r_mix != '0) ? ST_MIX : ST_ROUTE_OUT;
                end
            end
            ST_MIX: begin
                if (w_ph_last) begin
                    w_state_nxt = ST_ROUTE_OUT;
                end
            end
            ST_ROUTE_OUT: begin
                if (w_settle_end) begin
                    w_state_nxt = (r_drain != '0) ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (w_ph_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
`ifdef AQUAFLEX_SEQ_ABORT_EN
        // DONE already carries its registered pulse and exits on its own.
        if (abort && (r_state != ST_IDLE) && (r_state != ST_DONE)) begin
            w_state_nxt = ST_IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_settle <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_settle <= (w_state_nxt != r_state) ? '0 : r_settle + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc && w_sel_ok) begin
            r_in_sel  <= cmd_in_sel;
            r_out_sel <= cmd_out_sel;
            r_fill    <= cmd_fill;
            r_mix     <= cmd_mix;
            r_drain   <= cmd_drain;
        end
    end

    assign w_ph_start = ((w_state_nxt == ST_FILL) || (w_state_nxt == ST_MIX) ||
                         (w_state_nxt == ST_DRAIN)) && (w_state_nxt != r_state);

    always_comb begin
        case (w_state_nxt)
            ST_MIX:   w_ph_count = r_mix;
            ST_DRAIN: w_ph_count = r_drain;
            default:  w_ph_count = r_fill;
        endcase
    end

    aquaflex_peristaltic_phaser #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_phaser (
        .clk    (clk),
        .rst    (rst),
        .i_start(w_ph_start),
        .i_count(w_ph_count),
        .o_phase(w_phase),
        .o_last (w_ph_last)
    );

    // Every output is registered from the state it will be in during the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw0    <= '0;
            r_sw1    <= '0;
            r_sw2    <= '0;
            r_sw3    <= '0;
            r_pump_a <= '0;
            r_pump_c <= '0;
            r_mix_ph <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_sw0    <= ((w_state_nxt == ST_ROUTE_IN) || (w_state_nxt == ST_FILL)) ? w_in_m.a : '0;
            r_sw1    <= ((w_state_nxt == ST_ROUTE_IN) || (w_state_nxt == ST_FILL)) ? w_in_m.b : '0;
            r_sw2    <= ((w_state_nxt == ST_ROUTE_OUT) || (w_state_nxt == ST_DRAIN)) ? w_out_m.a : '0;
            r_sw3    <= ((w_state_nxt == ST_ROUTE_OUT) || (w_state_nxt == ST_DRAIN)) ? w_out_m.b : '0;
            r_pump_a <= (w_state_nxt == ST_FILL)  ? w_phase : '0;
            r_mix_ph <= (w_state_nxt == ST_MIX)   ? w_phase : '0;
            r_pump_c <= (w_state_nxt == ST_DRAIN) ? w_phase : '0;
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_done   <= (w_state_nxt == ST_DONE);
            r_err    <= w_acc && !w_sel_ok;
            r_ready  <= (w_state_nxt == ST_IDLE);
        end
    end

    assign sw0_open     = r_sw0;
    assign sw1_open     = r_sw1;
    assign sw2_open     = r_sw2;
    assign sw3_open     = r_sw3;
    assign pump_a_phase = r_pump_a;
    assign pump_c_phase = r_pump_c;
    assign mix_phase    = r_mix_ph;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign cmd_ready    = r_ready;

endmodule

// File: tb/tb_aquaflex_seq_ctrl.sv
// Randomized bench for aquaflex_seq_ctrl against a timeline model of each command.
// Build with AQUAFLEX_SEQ_ABORT_EN to also exercise abort.
module tb_aquaflex_seq_ctrl;

    localparam int STEP   = 4;
    localparam int SETTLE = 8;
    localparam logic [31:0] IDLE_VEC = 32'h2;

    typedef struct {
        int in_s;
        int out_s;
        int fill;
        int mix;
        int drain;
    } cmd_t;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_in_sel;
    logic [2:0] cmd_out_sel;
    logic [7:0] cmd_fill;
    logic [7:0] cmd_mix;
    logic [7:0] cmd_drain;
    logic [3:0] sw0_open, sw1_open, sw2_open, sw3_open;
    logic [2:0] pump_a_phase, pump_c_phase, mix_phase;
    logic       busy, done, err;
`ifdef AQUAFLEX_SEQ_ABORT_EN
    logic       abort;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cmd_id   = 0;
    int cyc      = 0;

    logic [3:0] IN0  [5] = '{4'b0000, 4'b1010, 4'b0110, 4'b0011, 4'b0000};
    logic [3:0] IN1  [5] = '{4'b1100, 4'b0110, 4'b0110, 4'b0110, 4'b0101};
    logic [3:0] OUT2 [5] = '{4'b1010, 4'b0110, 4'b0110, 4'b0110, 4'b0011};
    logic [3:0] OUT3 [5] = '{4'b0000, 4'b0101, 4'b1001, 4'b0011, 4'b0000};
    logic [2:0] PAT  [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

    aquaflex_seq_ctrl #(
        .STEP_CYCLES  (STEP),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_in_sel  (cmd_in_sel),
        .cmd_out_sel (cmd_out_sel),
        .cmd_fill    (cmd_fill),
        .cmd_mix     (cmd_mix),
        .cmd_drain   (cmd_drain),
        .sw0_open    (sw0_open),
        .sw1_open    (sw1_open),
        .sw2_open    (sw2_open),
        .sw3_open    (sw3_open),
        .pump_a_phase(pump_a_phase),
        .pump_c_phase(pump_c_phase),
        .mix_phase   (mix_phase),
        .busy        (busy),
        .done        (done),
        .err         (err)
`ifdef AQUAFLEX_SEQ_ABORT_EN
        ,
        .abort       (abort)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 60000) begin
            $display("FAIL watchdog cycles=%0d limit=60000", cyc);
            $fatal(1, "bench timeout");
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] obs_vec();
        return {3'b000, sw0_open, sw1_open, sw2_open, sw3_open,
                pump_a_phase, pump_c_phase, mix_phase, busy, done, cmd_ready, err};
    endfunction

    function automatic int cmd_len(input cmd_t c);
        return 2 * SETTLE + 6 * STEP * (c.fill + c.mix + c.drain) + 1;
    endfunction

    // Expected outputs k cycles after the acceptance edge; k = cmd_len is the done cycle.
    function automatic logic [31:0] expect_vec(input cmd_t c, input int k);
        int f  = 6 * STEP * c.fill;
        int m  = 6 * STEP * c.mix;
        int d  = 6 * STEP * c.drain;
        int L  = cmd_len(c);
        logic [3:0] s0 = 0, s1 = 0, s2 = 0, s3 = 0;
        logic [2:0] pa = 0, pc = 0, mx = 0;
        logic b = 0, dn = 0, rdy = 0;
        if (k > L) begin
            rdy = 1'b1;
        end else begin
            b = 1'b1;
            if (k <= SETTLE) begin
                s0 = IN0[c.in_s]; s1 = IN1[c.in_s];
            end else if (k <= SETTLE + f) begin
                s0 = IN0[c.in_s]; s1 = IN1[c.in_s];
                pa = PAT[((k - SETTLE - 1) / STEP) % 6];
            end else if (k <= SETTLE + f + m) begin
                mx = PAT[((k - SETTLE - f - 1) / STEP) % 6];
            end else if (k <= 2 * SETTLE + f + m) begin
                s2 = OUT2[c.out_s]; s3 = OUT3[c.out_s];
            end else if (k <= 2 * SETTLE + f + m + d) begin
                s2 = OUT2[c.out_s]; s3 = OUT3[c.out_s];
                pc = PAT[((k - 2 * SETTLE - f - m - 1) / STEP) % 6];
            end else begin
                dn = 1'b1;
            end
        end
        return {3'b000, s0, s1, s2, s3, pa, pc, mx, b, dn, rdy, 1'b0};
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.in_s  = $urandom_range(0, 4);
        c.out_s = $urandom_range(0, 4);
        c.fill  = $urandom_range(0, 3);
        c.mix   = $urandom_range(0, 2);
        c.drain = $urandom_range(0, 3);
        return c;
    endfunction

    function automatic cmd_t mk(input int i, input int o, input int f, input int m, input int d);
        cmd_t c;
        c.in_s = i; c.out_s = o; c.fill = f; c.mix = m; c.drain = d;
        return c;
    endfunction

    task automatic drive(input cmd_t c, input logic v);
        cmd_valid   = v;
        cmd_in_sel  = 3'(c.in_s);
        cmd_out_sel = 3'(c.out_s);
        cmd_fill    = 8'(c.fill);
        cmd_mix     = 8'(c.mix);
        cmd_drain   = 8'(c.drain);
    endtask

    // pre: acceptance edge already happened. hold: offer nxt throughout, so it is taken right after done.
    task automatic run_cmd(input cmd_t c, input bit pre, input bit hold, input cmd_t nxt, input int abort_at);
        int L = cmd_len(c);
        int last_k = (abort_at > 0) ? abort_at + 1 : L + 1;
        if (!pre) begin
            @(negedge clk);
            drive(c, 1'b1);
            @(posedge clk);
        end
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            if (abort_at > 0 && k == last_k)
                chk($sformatf("cmd%0d_abort_k%0d", cmd_id, k), obs_vec(), IDLE_VEC);
            else
                chk($sformatf("cmd%0d_k%0d", cmd_id, k), obs_vec(), expect_vec(c, k));
            if (hold) begin
                drive(nxt, 1'b1);
            end else if (k == last_k) begin
                cmd_valid = 1'b0;
            end else begin
                cmd_valid   = 1'($urandom_range(0, 1));
                cmd_in_sel  = 3'($urandom_range(0, 7));
                cmd_out_sel = 3'($urandom_range(0, 7));
                cmd_fill    = 8'($urandom_range(0, 255));
                cmd_mix     = 8'($urandom_range(0, 255));
                cmd_drain   = 8'($urandom_range(0, 255));
            end
`ifdef AQUAFLEX_SEQ_ABORT_EN
            abort = (k == abort_at);
`endif
            @(posedge clk);
        end
        cmd_id++;
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("idle_c%0d_%0d", cmd_id, i), obs_vec(), IDLE_VEC);
            cmd_valid = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic err_check(input cmd_t c);
        @(negedge clk);
        drive(c, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("err_pulse_%0d_%0d", c.in_s, c.out_s), obs_vec(), 32'h3);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("err_clear_%0d_%0d", c.in_s, c.out_s), obs_vec(), IDLE_VEC);
        @(posedge clk);
    endtask

    task automatic reset_mid_cmd(input cmd_t c);
        @(negedge clk);
        drive(c, 1'b1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_outputs", obs_vec() & ~32'h2, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        idle_check(4);
    endtask

    initial begin
        cmd_t cur;
        cmd_t nxt;
        bit   pending;
        bit   hold;
        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0), 1'b0);
`ifdef AQUAFLEX_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", obs_vec() & ~32'h2, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        idle_check(10);

        run_cmd(mk(1, 2, 1, 0, 1), 1'b0, 1'b0, mk(0, 0, 0, 0, 0), 0);
        idle_check(2);
        run_cmd(mk(0, 0, 0, 2, 0), 1'b0, 1'b0, mk(0, 0, 0, 0, 0), 0);
        idle_check(1);
        run_cmd(mk(4, 4, 0, 0, 0), 1'b0, 1'b0, mk(0, 0, 0, 0, 0), 0);

        err_check(mk(5, 2, 1, 1, 1));
        err_check(mk(0, 7, 1, 1, 1));

        run_cmd(mk(2, 3, 1, 1, 0), 1'b0, 1'b1, mk(3, 1, 0, 1, 2), 0);
        run_cmd(mk(3, 1, 0, 1, 2), 1'b1, 1'b0, mk(0, 0, 0, 0, 0), 0);
        idle_check(2);

`ifdef AQUAFLEX_SEQ_ABORT_EN
        run_cmd(mk(1, 0, 2, 1, 1), 1'b0, 1'b0, mk(0, 0, 0, 0, 0), SETTLE + 7);
        idle_check(5);
        run_cmd(mk(2, 4, 0, 0, 1), 1'b0, 1'b0, mk(0, 0, 0, 0, 0), 2 * SETTLE + 10);
        idle_check(3);
`endif

        reset_mid_cmd(mk(1, 1, 2, 0, 1));

        pending = 1'b0;
        cur = rand_cmd();
        for (int i = 0; i < 25; i++) begin
            hold = (i < 24) && ($urandom_range(0, 2) == 0);
            nxt  = rand_cmd();
            run_cmd(cur, pending, hold, nxt, 0);
            pending = hold;
            if (!hold) begin
                idle_check($urandom_range(0, 2));
                cur = rand_cmd();
            end else begin
                cur = nxt;
            end
        end
        idle_check(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
